prv_ex_int_driver: RTL and testbench

// - Pipeline-side driver for the privilege unit's exception/interrupt interface: collects commit-stage faults, ecall/ebreak/mret and raw interrupt lines, and drives them to the privilege unit.
// - Consumes the privilege unit's intr/intr_prv, then flushes the pipeline.
// - Sits between the execute/commit stage and the privilege unit (prv modport consumer).

---
 rtl/machine_mode_types_pkg.sv | 54 +++++
 rtl/irq_sync.sv | 20 ++
 rtl/prv_ex_int_driver.sv | 155 +++++++++++++++
 tb/tb_prv_ex_int_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode types for the privilege interface: privilege levels,
// the exception flag bitfield, its priority order and the driver FSM states.
package machine_mode_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    U_MODE = 2'b00,
    S_MODE = 2'b01,
    H_MODE = 2'b10,
    M_MODE = 2'b11
  } prv_lvl_t;

  localparam int unsigned EXC_W = 9;

  typedef struct packed {
    logic fault_insn;
    logic mal_insn;
    logic illegal_insn;
    logic breakpoint;
    logic env_m;
    logic mal_l;
    logic mal_s;
    logic fault_l;
    logic fault_s;
  } exc_vec_t;

  // Bit positions within exc_vec_t, highest priority first.
  localparam logic [3:0] EXC_PRIO [EXC_W] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4,
                                              4'd3, 4'd2, 4'd1, 4'd0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REPORT,
    S_FLUSH
  } ex_drv_state_t;

  function automatic exc_vec_t exc_pick(input exc_vec_t v);
    logic [EXC_W-1:0] raw;
    logic [EXC_W-1:0] sel;
    logic             found;
    raw   = v;
    sel   = '0;
    found = 1'b0;
    for (int unsigned p = 0; p < EXC_W; p++) begin
      if (!found && raw[EXC_PRIO[p]]) begin
        sel[EXC_PRIO[p]] = 1'b1;
        found            = 1'b1;
      end
    end
    return exc_vec_t'(sel);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for an asynchronous interrupt line.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[SYNC_STAGES-2:0], d};
  end

  assign q = sh[SYNC_STAGES-1];

endmodule

// File: rtl/prv_ex_int_driver.sv
// Commit-stage driver for the privilege unit: reports the top-priority
// exception, pulses mret, forwards interrupts and flushes after a trap.
module prv_ex_int_driver
  import machine_mode_types_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic [8:0]  exc_in,
  input  logic        mret_in,
  input  logic        timer_irq_a,
  input  logic        soft_irq,
  input  logic        ext_irq_a,
  input  logic        intr,
  input  logic [1:0]  intr_prv,
  output logic        fault_insn,
  output logic        mal_insn,
  output logic        illegal_insn,
  output logic        breakpoint,
  output logic        env_m,
  output logic        mal_l,
  output logic        mal_s,
  output logic        fault_l,
  output logic        fault_s,
  output logic [31:0] curr_epc,
  output logic [31:0] curr_epc_p4,
  output logic        timer_int,
  output logic        soft_int,
  output logic        ext_int,
  output logic [1:0]  timer_prv,
  output logic [1:0]  soft_prv,
  output logic [1:0]  ext_prv,
  output logic        ret,
  output logic [1:0]  prv_ret,
  output logic        commit_hold,
  output logic        pipe_flush,
  output logic        err_timeout
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_CYCLES - 1);

  ex_drv_state_t state;
  exc_vec_t      exc_q;
  logic [TW-1:0] to_cnt;
  logic [FW-1:0] fl_cnt;
  logic          soft_q;
  logic          exc_hit;
  logic          unused_intr_prv;

  assign unused_intr_prv = ^intr_prv;
  assign exc_hit         = commit_valid && (|exc_in);

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_timer_sync (
    .clk (CLK),
    .rst (RST),
    .d   (timer_irq_a),
    .q   (timer_int)
  );

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk (CLK),
    .rst (RST),
    .d   (ext_irq_a),
    .q   (ext_int)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      exc_q       <= '0;
      curr_epc    <= '0;
      ret         <= 1'b0;
      commit_hold <= 1'b0;
      pipe_flush  <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      fl_cnt      <= '0;
      soft_q      <= 1'b0;
    end else begin
      ret    <= 1'b0;
      soft_q <= soft_irq;
      case (state)
        S_IDLE: begin
          if (exc_hit) begin
            exc_q       <= exc_pick(exc_vec_t'(exc_in));
            curr_epc    <= commit_pc;
            to_cnt      <= '0;
            commit_hold <= 1'b1;
            state       <= S_REPORT;
          end else if (intr) begin
            // Interrupt-only trap: epc follows the commit slot only if it holds an insn.
            if (commit_valid) curr_epc <= commit_pc;
            fl_cnt      <= '0;
            pipe_flush  <= 1'b1;
            commit_hold <= 1'b1;
            state       <= S_FLUSH;
          end else if (commit_valid && mret_in) begin
            ret <= 1'b1;
          end
        end
        S_REPORT: begin
          if (intr) begin
            exc_q      <= '0;
            fl_cnt     <= '0;
            pipe_flush <= 1'b1;
            state      <= S_FLUSH;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            exc_q       <= '0;
            commit_hold <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (fl_cnt == FL_LAST) begin
            pipe_flush  <= 1'b0;
            commit_hold <= 1'b0;
            state       <= S_IDLE;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fault_insn   = exc_q.fault_insn;
  assign mal_insn     = exc_q.mal_insn;
  assign illegal_insn = exc_q.illegal_insn;
  assign breakpoint   = exc_q.breakpoint;
  assign env_m        = exc_q.env_m;
  assign mal_l        = exc_q.mal_l;
  assign mal_s        = exc_q.mal_s;
  assign fault_l      = exc_q.fault_l;
  assign fault_s      = exc_q.fault_s;

  assign curr_epc_p4 = curr_epc + 32'd4;
  assign soft_int    = soft_q;
  assign timer_prv   = M_MODE;
  assign soft_prv    = M_MODE;
  assign ext_prv     = M_MODE;
  assign prv_ret     = M_MODE;

endmodule

// File: tb/tb_prv_ex_int_driver.sv
// Directed scoreboard bench for prv_ex_int_driver: expected outputs are queued
// as each step is driven and compared at the following falling edge.
module tb_prv_ex_int_driver;

  logic        CLK = 1'b0;
  logic        RST;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [8:0]  exc_in;
  logic        mret_in;
  logic        timer_irq_a, soft_irq, ext_irq_a;
  logic        intr;
  logic [1:0]  intr_prv;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
  logic        mal_l, mal_s, fault_l, fault_s;
  logic [31:0] curr_epc, curr_epc_p4;
  logic        timer_int, soft_int, ext_int;
  logic [1:0]  timer_prv, soft_prv, ext_prv, prv_ret;
  logic        ret, commit_hold, pipe_flush, err_timeout;

  localparam logic [8:0] E_FI = 9'h100, E_MI = 9'h080, E_IL = 9'h040;
  localparam logic [8:0] E_BP = 9'h020, E_EM = 9'h010, E_ML = 9'h008;
  localparam logic [8:0] E_MS = 9'h004, E_FL = 9'h002, E_FS = 9'h001;

  always #5 CLK = ~CLK;

  prv_ex_int_driver #(.SYNC_STAGES(2), .FLUSH_CYCLES(2), .ACK_TIMEOUT(15)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .exc_in       (exc_in),
    .mret_in      (mret_in),
    .timer_irq_a  (timer_irq_a),
    .soft_irq     (soft_irq),
    .ext_irq_a    (ext_irq_a),
    .intr         (intr),
    .intr_prv     (intr_prv),
    .fault_insn   (fault_insn),
    .mal_insn     (mal_insn),
    .illegal_insn (illegal_insn),
    .breakpoint   (breakpoint),
    .env_m        (env_m),
    .mal_l        (mal_l),
    .mal_s        (mal_s),
    .fault_l      (fault_l),
    .fault_s      (fault_s),
    .curr_epc     (curr_epc),
    .curr_epc_p4  (curr_epc_p4),
    .timer_int    (timer_int),
    .soft_int     (soft_int),
    .ext_int      (ext_int),
    .timer_prv    (timer_prv),
    .soft_prv     (soft_prv),
    .ext_prv      (ext_prv),
    .ret          (ret),
    .prv_ret      (prv_ret),
    .commit_hold  (commit_hold),
    .pipe_flush   (pipe_flush),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    string       tag;
    logic [8:0]  exc;
    logic [31:0] epc;
    logic        ret, hold, flush, err;
    logic [2:0]  irq;   // {timer, soft, ext}
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [8:0]  m_exc;
  logic [31:0] m_epc;
  logic        m_ret, m_hold, m_flush, m_err;
  logic [2:0]  m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag   = tag;
    e.exc   = m_exc;
    e.epc   = m_epc;
    e.ret   = m_ret;
    e.hold  = m_hold;
    e.flush = m_flush;
    e.err   = m_err;
    e.irq   = m_irq;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_depth", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".exc"}, 32'({fault_insn, mal_insn, illegal_insn, breakpoint, env_m,
                                mal_l, mal_s, fault_l, fault_s}), 32'(e.exc));
      chk({e.tag, ".epc"}, curr_epc, e.epc);
      chk({e.tag, ".epc_p4"}, curr_epc_p4, e.epc + 32'd4);
      chk({e.tag, ".ret"}, 32'(ret), 32'(e.ret));
      chk({e.tag, ".hold"}, 32'(commit_hold), 32'(e.hold));
      chk({e.tag, ".flush"}, 32'(pipe_flush), 32'(e.flush));
      chk({e.tag, ".err"}, 32'(err_timeout), 32'(e.err));
      chk({e.tag, ".irq"}, 32'({timer_int, soft_int, ext_int}), 32'(e.irq));
      chk({e.tag, ".prv"}, 32'({timer_prv, soft_prv, ext_prv, prv_ret}), 32'hFF);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic tick(input string tag);
    push(tag);
    step();
    pop_check();
  endtask

  task automatic idle_in();
    commit_valid = 1'b0;
    commit_pc    = '0;
    exc_in       = '0;
    mret_in      = 1'b0;
    intr         = 1'b0;
  endtask

  task automatic ack_flush(input string tag);
    idle_in();
    intr    = 1'b1;
    m_exc   = '0;
    m_flush = 1'b1;
    m_hold  = 1'b1;
    tick({tag, ".ack"});
    intr = 1'b0;
    tick({tag, ".flush2"});
    m_flush = 1'b0;
    m_hold  = 1'b0;
    tick({tag, ".idle"});
  endtask

  initial begin
    RST         = 1'b1;
    idle_in();
    intr_prv    = 2'b11;
    timer_irq_a = 1'b0;
    soft_irq    = 1'b0;
    ext_irq_a   = 1'b0;
    m_exc = '0; m_epc = '0; m_ret = 1'b0; m_hold = 1'b0;
    m_flush = 1'b0; m_err = 1'b0; m_irq = '0;

    repeat (2) @(negedge CLK);
    push("reset");
    pop_check();
    RST = 1'b0;
    tick("post_reset");

    // Two flags: only illegal_insn survives priority; REPORT ignores new commits.
    commit_valid = 1'b1; commit_pc = 32'h100; exc_in = E_IL | E_ML;
    m_exc = E_IL; m_epc = 32'h100; m_hold = 1'b1;
    tick("exc_cap");
    commit_pc = 32'h200; exc_in = E_FI;
    tick("report_ign1");
    tick("report_ign2");
    ack_flush("exc1");

    // epc+4 wraps at the top of the address space.
    commit_valid = 1'b1; commit_pc = 32'hFFFF_FFFC; exc_in = E_EM;
    m_exc = E_EM; m_epc = 32'hFFFF_FFFC; m_hold = 1'b1;
    tick("wrap_cap");
    ack_flush("wrap");

    // mret pulse, mret without commit_valid, and mret suppressed by exception.
    commit_valid = 1'b1; mret_in = 1'b1; commit_pc = 32'h300;
    m_ret = 1'b1;
    tick("mret");
    idle_in();
    m_ret = 1'b0;
    tick("mret_end");
    mret_in = 1'b1;
    tick("mret_novalid");
    commit_valid = 1'b1; mret_in = 1'b1; exc_in = E_FS; commit_pc = 32'h304;
    m_exc = E_FS; m_epc = 32'h304; m_hold = 1'b1;
    tick("mret_sup");
    ack_flush("mret_sup");

    // Interrupt lines: soft has one flop, async lines rise mid-cycle and take two.
    soft_irq = 1'b1;
    #2;
    timer_irq_a = 1'b1;
    ext_irq_a   = 1'b1;
    m_irq = 3'b010;
    tick("irq_e1");
    intr = 1'b1;
    m_irq = 3'b111; m_flush = 1'b1; m_hold = 1'b1;
    tick("irq_trap");
    ext_irq_a = 1'b0; commit_valid = 1'b1; exc_in = E_FI; commit_pc = 32'h500;
    tick("flush_ign");
    idle_in();
    m_flush = 1'b0; m_hold = 1'b0; m_irq = 3'b110;
    tick("irq_level");
    timer_irq_a = 1'b0; soft_irq = 1'b0;
    m_irq = 3'b100;
    tick("irq_fall1");
    m_irq = 3'b000;
    tick("irq_fall2");

    // Interrupt-only trap with a valid commit slot captures its pc.
    commit_valid = 1'b1; commit_pc = 32'h400; intr = 1'b1;
    m_epc = 32'h400; m_flush = 1'b1; m_hold = 1'b1;
    tick("itrap_pc");
    idle_in();
    tick("itrap_fl2");
    m_flush = 1'b0; m_hold = 1'b0;
    tick("itrap_idle");

    // No intr: REPORT lasts 15 cycles, then sticky err_timeout.
    commit_valid = 1'b1; commit_pc = 32'h600; exc_in = E_FL;
    m_exc = E_FL; m_epc = 32'h600; m_hold = 1'b1;
    tick("to_cap");
    idle_in();
    for (int i = 0; i < 14; i++) tick("to_wait");
    m_exc = '0; m_hold = 1'b0; m_err = 1'b1;
    tick("to_fire");
    repeat (3) tick("to_sticky");
    commit_valid = 1'b1; commit_pc = 32'h610; exc_in = E_BP;
    m_exc = E_BP; m_epc = 32'h610; m_hold = 1'b1;
    tick("after_to");
    ack_flush("after_to");

    // Reset in the first flush cycle drops everything asynchronously.
    commit_valid = 1'b1; commit_pc = 32'h700; exc_in = E_MS;
    m_exc = E_MS; m_epc = 32'h700; m_hold = 1'b1;
    tick("rst_cap");
    idle_in();
    intr = 1'b1;
    m_exc = '0; m_flush = 1'b1;
    tick("rst_fl1");
    intr = 1'b0;
    #1;
    RST = 1'b1;
    #1;
    m_flush = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_epc = '0;
    push("rst_async");
    pop_check();
    @(negedge CLK);
    RST = 1'b0;
    tick("rst_rel");
    commit_valid = 1'b1; commit_pc = 32'h800; exc_in = E_MI | E_FS;
    m_exc = E_MI; m_epc = 32'h800; m_hold = 1'b1;
    tick("post_rst_cap");
    ack_flush("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
